// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters, with registered operands and a single tagged response channel.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   rr_ptr;
  logic   op_id;
  logic   grant;
  logic   take;
  logic   ctrl_legal;

  // rr_ptr only breaks ties; a lone requester always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = rr_ptr;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign take       = req0_ready || req1_ready;

  always_comb begin
    case (alu_ctrl)
      4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      op_id     <= 1'b0;
      alu_ctrl  <= 4'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            alu_ctrl <= grant ? req1_ctrl : req0_ctrl;
            alu_a    <= grant ? req1_a    : req0_a;
            alu_b    <= grant ? req1_b    : req0_b;
            op_id    <= grant;
            rr_ptr   <= ~grant;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands.
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          if (ctrl_legal) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops push expected responses,
// a monitor pops and compares on every accepted response.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
    logic         err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // External ALU; unsupported codes produce garbage that the DUT must mask.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] d, input logic z, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.zero = z; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every accepted response against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL rsp_unexpected: got id=%0d data=0x%08h expected none", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id",   {31'd0, rsp_id},   {31'd0, e.id});
          check("rsp_data", rsp_data,          e.data);
          check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          check("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
          $display("[TB] rsp id=%0d data=0x%08h zero=%0d err=%0d", rsp_id, rsp_data, rsp_zero, rsp_err);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_ctrl"},  {28'd0, alu_ctrl},  32'd0);
    check({tag, "_alu_a"},     alu_a,              32'd0);
    check({tag, "_alu_b"},     alu_b,              32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_id"},    {31'd0, rsp_id},    32'd0);
    check({tag, "_rsp_data"},  rsp_data,           32'd0);
    check({tag, "_rsp_zero"},  {31'd0, rsp_zero},  32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one op, waits (bounded) for its handshake, returns one step after it.
  task automatic issue(input logic id, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ed, input logic ez,
                       input logic ee, input bit push_it);
    int n = 0;
    if (id) begin req1_ctrl = c; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_ctrl = c; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
    if (!(id ? req1_ready : req0_ready)) begin
      tests++; fails++;
      $display("[TB] FAIL issue_timeout: req%0d ready got 0 expected 1", id);
    end else if (push_it) begin
      push(id, ed, ez, ee);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_ctrl = 0; req0_a = 0; req0_b = 0;
    req1_ctrl = 0; req1_a = 0; req1_b = 0;
    #3;
    check_all_zero("reset");
    check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single add, cycle-accurate latency
    rsp_ready = 1'b1;
    req0_ctrl = 4'b0010; req0_a = 5; req0_b = 7; req0_valid = 1'b1;
    @(negedge clk);
    check("t1_ready_c0", {31'd0, req0_ready}, 32'd1);
    push(1'b0, 32'd12, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_alu_ctrl_c1", {28'd0, alu_ctrl}, 32'h2);
    check("t1_alu_a_c1", alu_a, 32'd5);
    check("t1_alu_b_c1", alu_b, 32'd7);
    check("t1_rsp_valid_c1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("t1_rsp_valid_c2", {31'd0, rsp_valid}, 32'd1);
    drain();

    // T2: both requesters continuously valid after reset alternate 0,1,0,1
    do_reset();
    req0_ctrl = 4'b0010; req0_a = 3;     req0_b = 4;
    req1_ctrl = 4'b0001; req1_a = 'hF0;  req1_b = 'h0F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); n++; end
      check("t2_grant_is_req1", {31'd0, req1_ready}, k % 2);
      check("t2_grant_is_req0", {31'd0, req0_ready}, 1 - (k % 2));
      if (k % 2 == 0) push(1'b0, 32'd7, 1'b0, 1'b0);
      else            push(1'b1, 32'hFF, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // T3: backpressured response stays stable; no grants while in RESP
    rsp_ready = 1'b0;
    issue(1'b1, 4'b0110, 9, 9, 32'd0, 1'b1, 1'b0, 1'b1);
    req0_ctrl = 4'b0010; req0_a = 1; req0_b = 1; req0_valid = 1'b1;
    req1_ctrl = 4'b0010; req1_a = 2; req1_b = 2; req1_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("t3_hold_data", rsp_data, 32'd0);
      check("t3_hold_zero", {31'd0, rsp_zero}, 32'd1);
      check("t3_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("t3_req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // T4: illegal code flags error and zeroes data; following slt is clean
    issue(1'b0, 4'b1111, 3, 4, 32'd0, 1'b0, 1'b1, 1'b1);
    drain();
    issue(1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    drain();

    // T5: reset during EXEC discards the op; later req1 op completes normally
    issue(1'b0, 4'b0010, 1, 1, 32'd2, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    @(posedge clk); #1;
    check("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
    issue(1'b1, 4'b0010, 10, 20, 32'd30, 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
